// File: rtl/sc_pc_sequencer.sv
// Fetch / next-PC sequencer. It requests instruction words, strobes the IR
// load, selects the next PC (sequential, branch, jump or trap vector) and
// drives the PC register load once per instruction.
//
// Handshake: imem_req is high in FETCH and WAIT. imem_ready is only looked at
// in WAIT; ready=1 in a WAIT cycle means the word is on the bus this cycle, so
// ir_load_OutLow goes low in that same cycle and the FSM moves to DECODE.
module sc_pc_sequencer #(
   parameter int                              RegGENERAL_DATAWIDTH = 32,
   parameter logic [RegGENERAL_DATAWIDTH-1:0] RESET_ADDR           = 32'd2048,
   parameter logic [RegGENERAL_DATAWIDTH-1:0] TRAP_VECTOR          = 32'd4,
   parameter int                              MEM_TIMEOUT          = 16
) (
   input  logic                            SC_PCSEQ_CLOCK_50,
   input  logic                            SC_PCSEQ_RESET_InLow,
   input  logic [RegGENERAL_DATAWIDTH-1:0] SC_PCSEQ_pc_InBUS,
   input  logic                            SC_PCSEQ_imem_ready_InHigh,
   input  logic                            SC_PCSEQ_branch_valid_InHigh,
   input  logic [RegGENERAL_DATAWIDTH-1:0] SC_PCSEQ_branch_target_InBUS,
   input  logic                            SC_PCSEQ_jump_valid_InHigh,
   input  logic [RegGENERAL_DATAWIDTH-1:0] SC_PCSEQ_jump_target_InBUS,
   input  logic                            SC_PCSEQ_trap_InHigh,
   input  logic                            SC_PCSEQ_halt_InHigh,
   input  logic                            SC_PCSEQ_resume_InHigh,
   output logic                            SC_PCSEQ_pc_clear_OutLow,
   output logic                            SC_PCSEQ_pc_load_OutLow,
   output logic [RegGENERAL_DATAWIDTH-1:0] SC_PCSEQ_pc_next_OutBUS,
   output logic                            SC_PCSEQ_imem_req_OutHigh,
   output logic                            SC_PCSEQ_ir_load_OutLow,
   output logic                            SC_PCSEQ_trap_OutHigh,
   output logic [1:0]                      SC_PCSEQ_trap_cause_OutBUS,
   output logic [2:0]                      SC_PCSEQ_state_OutBUS
);

   localparam int W  = RegGENERAL_DATAWIDTH;
   // Counter only has to hold 0 .. MEM_TIMEOUT-1.
   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   localparam logic [1:0] CAUSE_EXT     = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   localparam logic [1:0] CAUSE_MISALGN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_DECODE = 3'd3,
      S_UPDATE = 3'd4,
      S_TRAP   = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t        state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [W-1:0]  pc_next_q,  pc_next_d;
   logic [1:0]    cause_q,    cause_d;
   logic          pc_load_q,  pc_load_d;
   logic          imem_req_q, imem_req_d;
   logic          trap_q,     trap_d;

   logic [W-1:0]  pc_plus4;
   logic [W-1:0]  sel_target;
   logic          redirect;

   // Next-PC candidates: jump beats branch; PC+4 wraps naturally at W bits.
   always_comb begin
      pc_plus4   = SC_PCSEQ_pc_InBUS + W'(4);
      redirect   = SC_PCSEQ_jump_valid_InHigh | SC_PCSEQ_branch_valid_InHigh;
      sel_target = pc_plus4;
      if (SC_PCSEQ_jump_valid_InHigh) begin
         sel_target = SC_PCSEQ_jump_target_InBUS;
      end else if (SC_PCSEQ_branch_valid_InHigh) begin
         sel_target = SC_PCSEQ_branch_target_InBUS;
      end
   end

   // Next-state, next-PC, trap cause and registered output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_next_d = pc_next_q;
      cause_d   = cause_q;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (SC_PCSEQ_imem_ready_InHigh) begin
               state_d = S_DECODE;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_TRAP;
               cause_d   = CAUSE_TIMEOUT;
               pc_next_d = TRAP_VECTOR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DECODE: begin
            if (SC_PCSEQ_trap_InHigh) begin
               state_d   = S_TRAP;
               cause_d   = CAUSE_EXT;
               pc_next_d = TRAP_VECTOR;
            end else if (redirect && (sel_target[1:0] != 2'b00)) begin
               state_d   = S_TRAP;
               cause_d   = CAUSE_MISALGN;
               pc_next_d = TRAP_VECTOR;
            end else if (SC_PCSEQ_halt_InHigh) begin
               state_d   = S_HALT;
               pc_next_d = pc_plus4;
            end else begin
               state_d   = S_UPDATE;
               pc_next_d = sel_target;
            end
         end
         S_UPDATE: state_d = S_FETCH;
         S_TRAP:   state_d = S_FETCH;
         S_HALT: begin
            if (SC_PCSEQ_resume_InHigh) begin
               state_d = S_FETCH;
            end
         end
         default:  state_d = S_IDLE;
      endcase
      if (state_d == S_FETCH) begin
         cnt_d = '0;
      end
      // Outputs are decoded from the next state so they line up with state_q.
      pc_load_d  = !((state_d == S_UPDATE) || (state_d == S_TRAP) ||
                     ((state_d == S_HALT) && (state_q != S_HALT)));
      imem_req_d = (state_d == S_FETCH) || (state_d == S_WAIT);
      trap_d     = (state_d == S_TRAP);
   end

   // State and registered outputs; async reset clears everything at once.
   always_ff @(posedge SC_PCSEQ_CLOCK_50 or negedge SC_PCSEQ_RESET_InLow) begin
      if (!SC_PCSEQ_RESET_InLow) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         pc_next_q  <= RESET_ADDR;
         cause_q    <= 2'b00;
         pc_load_q  <= 1'b1;
         imem_req_q <= 1'b0;
         trap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_next_q  <= pc_next_d;
         cause_q    <= cause_d;
         pc_load_q  <= pc_load_d;
         imem_req_q <= imem_req_d;
         trap_q     <= trap_d;
      end
   end

   assign SC_PCSEQ_pc_clear_OutLow   = 1'b1;
   assign SC_PCSEQ_pc_load_OutLow    = pc_load_q;
   assign SC_PCSEQ_pc_next_OutBUS    = pc_next_q;
   assign SC_PCSEQ_imem_req_OutHigh  = imem_req_q;
   assign SC_PCSEQ_ir_load_OutLow    = !((state_q == S_WAIT) && SC_PCSEQ_imem_ready_InHigh);
   assign SC_PCSEQ_trap_OutHigh      = trap_q;
   assign SC_PCSEQ_trap_cause_OutBUS = cause_q;
   assign SC_PCSEQ_state_OutBUS      = state_q;

endmodule

// File: tb/tb_sc_pc_sequencer.sv
// Bench for sc_pc_sequencer: directed instruction sequence, a behavioural PC
// register closing the loop, and a scoreboard of expected commits
// ({trap, cause, pc_next}) popped whenever pc_load_OutLow goes low.
module tb_sc_pc_sequencer;

   localparam int W  = 32;
   localparam int EW = W + 3;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] pc_reg;
   logic         imem_ready = 1'b0;
   logic         branch_valid = 1'b0;
   logic [W-1:0] branch_target = '0;
   logic         jump_valid = 1'b0;
   logic [W-1:0] jump_target = '0;
   logic         trap_in = 1'b0;
   logic         halt_in = 1'b0;
   logic         resume_in = 1'b0;
   logic         pc_clear;
   logic         pc_load;
   logic [W-1:0] pc_next;
   logic         imem_req;
   logic         ir_load;
   logic         trap_out;
   logic [1:0]   trap_cause;
   logic [2:0]   state;

   sc_pc_sequencer dut (
      .SC_PCSEQ_CLOCK_50            (clk),
      .SC_PCSEQ_RESET_InLow         (rst_n),
      .SC_PCSEQ_pc_InBUS            (pc_reg),
      .SC_PCSEQ_imem_ready_InHigh   (imem_ready),
      .SC_PCSEQ_branch_valid_InHigh (branch_valid),
      .SC_PCSEQ_branch_target_InBUS (branch_target),
      .SC_PCSEQ_jump_valid_InHigh   (jump_valid),
      .SC_PCSEQ_jump_target_InBUS   (jump_target),
      .SC_PCSEQ_trap_InHigh         (trap_in),
      .SC_PCSEQ_halt_InHigh         (halt_in),
      .SC_PCSEQ_resume_InHigh       (resume_in),
      .SC_PCSEQ_pc_clear_OutLow     (pc_clear),
      .SC_PCSEQ_pc_load_OutLow      (pc_load),
      .SC_PCSEQ_pc_next_OutBUS      (pc_next),
      .SC_PCSEQ_imem_req_OutHigh    (imem_req),
      .SC_PCSEQ_ir_load_OutLow      (ir_load),
      .SC_PCSEQ_trap_OutHigh        (trap_out),
      .SC_PCSEQ_trap_cause_OutBUS   (trap_cause),
      .SC_PCSEQ_state_OutBUS        (state)
   );

   // PC register model: reset 2048, active-low clear/load, falling-edge capture
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n)         pc_reg <= 32'd2048;
      else if (!pc_clear) pc_reg <= '0;
      else if (!pc_load)  pc_reg <= pc_next;
   end

   // scoreboard
   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every PC commit is compared with the next expected entry
   logic [EW-1:0] mon_e;
   always @(negedge clk) begin
      if (rst_n && (pc_load === 1'b0)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL commit_unexpected: got pc_next=%h trap=%b cause=%b expected no commit",
                     pc_next, trap_out, trap_cause);
         end else begin
            mon_e = exp_q.pop_front();
            check("commit", {trap_out, trap_cause, pc_next}, mon_e);
         end
      end
   end

   // driver tasks
   task automatic wait_wait_state();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((state !== 3'd2) && (n < 40));
      if (state !== 3'd2) begin
         checks++;
         errors++;
         $display("FAIL wait_for_WAIT: got state %0d expected 2 within 40 cycles", state);
      end
   endtask

   // One instruction: ready after 'delay' empty WAIT cycles, then decode inputs.
   task automatic do_instr(input int delay, input logic bv, input logic [W-1:0] bt,
                           input logic jv, input logic [W-1:0] jt, input logic tr,
                           input logic hl, input logic [W-1:0] exp_pc,
                           input logic exp_trap, input logic [1:0] exp_cause);
      wait_wait_state();
      imem_ready = 1'b0;
      for (int i = 0; i < delay; i++) @(negedge clk);
      imem_ready    = 1'b1;
      branch_valid  = bv;
      branch_target = bt;
      jump_valid    = jv;
      jump_target   = jt;
      trap_in       = tr;
      halt_in       = hl;
      exp_q.push_back({exp_trap, exp_cause, exp_pc});
      #1 check("ir_load_in_wait", EW'(ir_load), EW'(0));
      @(negedge clk);
      imem_ready = 1'b0;
      check("decode_state", EW'(state), EW'(3));
      check("decode_imem_req", EW'(imem_req), EW'(0));
      @(negedge clk);
      branch_valid = 1'b0;
      jump_valid   = 1'b0;
      trap_in      = 1'b0;
      halt_in      = 1'b0;
   endtask

   task automatic do_timeout(input int exp_cycles);
      int n = 0;
      wait_wait_state();
      imem_ready = 1'b0;
      exp_q.push_back({1'b1, 2'b10, 32'd4});
      while ((state === 3'd2) && (n < 40)) begin
         n++;
         @(negedge clk);
      end
      check("timeout_wait_cycles", EW'(n), EW'(exp_cycles));
      check("timeout_state", EW'(state), EW'(5));
   endtask

   task automatic check_trap_dropped();
      @(negedge clk);
      check("trap_one_cycle", EW'(trap_out), EW'(0));
      check("after_trap_state", EW'(state), EW'(1));
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_state", EW'(state), EW'(0));
      check("rst_outputs", EW'({pc_load, pc_clear, ir_load, imem_req, trap_out, trap_cause}),
            EW'(7'b1110000));
      check("rst_pc_next", EW'(pc_next), EW'(32'd2048));
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_to_fetch", EW'(state), EW'(1));
      check("fetch_imem_req", EW'(imem_req), EW'(1));

      // sequential x2
      do_instr(0, 0, 0, 0, 0, 0, 0, 32'd2052, 0, 2'b00);
      check("update_state", EW'(state), EW'(4));
      do_instr(0, 0, 0, 0, 0, 0, 0, 32'd2056, 0, 2'b00);
      // jump beats branch
      do_instr(0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h200, 0, 2'b00);
      // misaligned branch target
      do_instr(1, 1, 32'h102, 0, 0, 0, 0, 32'd4, 1, 2'b11);
      check("misalign_state", EW'(state), EW'(5));
      check_trap_dropped();
      // timeout after 16 WAIT cycles
      do_timeout(16);
      check_trap_dropped();
      // ready on the 16th WAIT cycle wins
      do_instr(15, 0, 0, 0, 0, 0, 0, 32'd8, 0, 2'b10);
      // jump to top of address space, then wrap; resume ignored outside HALT
      do_instr(2, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 2'b10);
      resume_in = 1'b1;
      do_instr(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 2'b10);
      resume_in = 1'b0;
      // external trap beats a valid branch
      do_instr(0, 1, 32'h300, 0, 0, 1, 0, 32'd4, 1, 2'b01);
      check_trap_dropped();
      // halt: PC+4 committed once, no fetch until resume
      do_instr(0, 0, 0, 0, 0, 0, 1, 32'd8, 0, 2'b01);
      check("halt_state", EW'(state), EW'(6));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("halt_hold", EW'({state, imem_req, pc_load}), EW'({3'd6, 1'b0, 1'b1}));
      end
      resume_in = 1'b1;
      @(negedge clk);
      resume_in = 1'b0;
      check("resume_to_fetch", EW'(state), EW'(1));
      do_instr(0, 0, 0, 0, 0, 0, 0, 32'd12, 0, 2'b01);

      // asynchronous reset in WAIT
      wait_wait_state();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", EW'(state), EW'(0));
      check("async_rst_imem_req", EW'(imem_req), EW'(0));
      check("async_rst_pc_next", EW'(pc_next), EW'(32'd2048));
      check("async_rst_cause", EW'(trap_cause), EW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_idle", EW'(state), EW'(0));
      @(negedge clk);
      check("post_rst_fetch", EW'(state), EW'(1));
      do_instr(0, 0, 0, 0, 0, 0, 0, 32'd2052, 0, 2'b00);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", EW'(exp_q.size()), EW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
